// File: rtl/fp_mul_pipe.sv
// Three-stage elastic IEEE-754 multiplier: decode/multiply, normalise/round, range-check/pack.
// Subnormal operands are treated as zero; RNE and RTZ rounding; tag rides along unchanged.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   round_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned EW = EXP_W + 2;

    localparam logic [EW-1:0] Bias   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EW-1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]  QNan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic ready2, ready3;

    // Stage 1 registers
    logic             v1_q, v1_d, sign1_q, sign1_d, rm1_q, rm1_d, spec1_q, spec1_d;
    logic [EW-1:0]    exp1_q, exp1_d;
    logic [PW-1:0]    prod1_q, prod1_d;
    logic [W-1:0]     sres1_q, sres1_d;
    logic [4:0]       sflg1_q, sflg1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // Stage 2 registers
    logic             v2_q, v2_d, sign2_q, sign2_d, rm2_q, rm2_d, spec2_q, spec2_d, nx2_q, nx2_d;
    logic [EW-1:0]    exp2_q, exp2_d;
    logic [MAN_W-1:0] frac2_q, frac2_d;
    logic [W-1:0]     sres2_q, sres2_d;
    logic [4:0]       sflg2_q, sflg2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    // Output registers
    logic             v3_q, v3_d;
    logic [W-1:0]     res3_q, res3_d;
    logic [4:0]       flg3_q, flg3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    always_comb begin
        ready3   = !v3_q || out_ready;
        ready2   = !v2_q || ready3;
        in_ready = !v1_q || ready2;
    end

    // S1: classify operands, detect special results, multiply significands
    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sgn;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;

    always_comb begin
        sa     = op_a[W-1];
        sb     = op_b[W-1];
        ea     = op_a[W-2:MAN_W];
        eb     = op_b[W-2:MAN_W];
        fa     = op_a[MAN_W-1:0];
        fb     = op_b[MAN_W-1:0];
        sgn    = sa ^ sb;
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];

        v1_d    = in_ready ? in_valid : v1_q;
        sign1_d = sign1_q;
        rm1_d   = rm1_q;
        exp1_d  = exp1_q;
        prod1_d = prod1_q;
        spec1_d = spec1_q;
        sres1_d = sres1_q;
        sflg1_d = sflg1_q;
        tag1_d  = tag1_q;
        if (in_valid && in_ready) begin
            sign1_d = sgn;
            rm1_d   = round_mode;
            tag1_d  = in_tag;
            exp1_d  = {2'b00, ea} + {2'b00, eb} - Bias;
            prod1_d = {{(MAN_W+1){1'b0}}, 1'b1, fa} * {{(MAN_W+1){1'b0}}, 1'b1, fb};
            spec1_d = 1'b1;
            sflg1_d = '0;
            if (a_nan || b_nan) begin
                sres1_d = QNan;
                sflg1_d = {a_snan || b_snan, 4'b0000};
            end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                sres1_d = QNan;
                sflg1_d = 5'b10000;
            end else if (a_inf || b_inf) begin
                sres1_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (a_zero || b_zero) begin
                sres1_d = {sgn, {(W-1){1'b0}}};
            end else begin
                spec1_d = 1'b0;
                sres1_d = '0;
            end
        end
    end

    // S2: normalise so the hidden bit sits at the top, then round
    logic [PW-1:0]    pn;
    logic [EW-1:0]    e_n;
    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic             g, r, s, inc;

    always_comb begin
        pn     = prod1_q[PW-1] ? prod1_q : (prod1_q << 1);
        e_n    = exp1_q + {{(EW-1){1'b0}}, prod1_q[PW-1]};
        mant   = pn[PW-1:MAN_W+1];
        g      = pn[MAN_W];
        r      = pn[MAN_W-1];
        s      = |pn[MAN_W-2:0];
        inc    = !rm1_q && g && (r || s || mant[0]);
        mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};

        v2_d    = ready2 ? v1_q : v2_q;
        sign2_d = sign2_q;
        rm2_d   = rm2_q;
        spec2_d = spec2_q;
        nx2_d   = nx2_q;
        exp2_d  = exp2_q;
        frac2_d = frac2_q;
        sres2_d = sres2_q;
        sflg2_d = sflg2_q;
        tag2_d  = tag2_q;
        if (v1_q && ready2) begin
            sign2_d = sign1_q;
            rm2_d   = rm1_q;
            spec2_d = spec1_q;
            sres2_d = sres1_q;
            sflg2_d = sflg1_q;
            tag2_d  = tag1_q;
            nx2_d   = g || r || s;
            // Carry out of rounding leaves 1.000..., so the fraction is just the shifted bits
            exp2_d  = e_n + {{(EW-1){1'b0}}, mant_r[MAN_W+1]};
            frac2_d = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        end
    end

    // S3: range check and pack
    always_comb begin
        v3_d   = ready3 ? v2_q : v3_q;
        res3_d = res3_q;
        flg3_d = flg3_q;
        tag3_d = tag3_q;
        if (v2_q && ready3) begin
            tag3_d = tag2_q;
            if (spec2_q) begin
                res3_d = sres2_q;
                flg3_d = sflg2_q;
            end else if ($signed(exp2_q) >= $signed(ExpMax)) begin
                res3_d = rm2_q ? {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                               : {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flg3_d = 5'b00101;
            end else if (exp2_q[EW-1] || (exp2_q == '0)) begin
                res3_d = {sign2_q, {(W-1){1'b0}}};
                flg3_d = 5'b00011;
            end else begin
                res3_d = {sign2_q, exp2_q[EXP_W-1:0], frac2_q};
                flg3_d = {4'b0000, nx2_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            res3_q <= '0;
            flg3_q <= '0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            res3_q <= res3_d;
            flg3_q <= flg3_d;
            tag3_q <= tag3_d;
        end
    end

    always_ff @(posedge clk) begin
        sign1_q <= sign1_d;
        rm1_q   <= rm1_d;
        exp1_q  <= exp1_d;
        prod1_q <= prod1_d;
        spec1_q <= spec1_d;
        sres1_q <= sres1_d;
        sflg1_q <= sflg1_d;
        tag1_q  <= tag1_d;
        sign2_q <= sign2_d;
        rm2_q   <= rm2_d;
        spec2_q <= spec2_d;
        nx2_q   <= nx2_d;
        exp2_q  <= exp2_d;
        frac2_q <= frac2_d;
        sres2_q <= sres2_d;
        sflg2_q <= sflg2_d;
        tag2_q  <= tag2_d;
    end

    always_comb begin
        out_valid = v3_q;
        result    = res3_q;
        flags     = flg3_q;
        out_tag   = tag3_q;
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: vector table streamed through a scoreboard, backpressure and reset runs.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, round_mode, out_valid, out_ready;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  flags;
    logic [3:0]  in_tag, out_tag;

    fp_mul_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .round_mode (round_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic [3:0]  tag;
        int          cyc;
    } sb_t;

    localparam int NV = 21;
    vec_t vt [NV];
    sb_t  sb [$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic        bp_mode = 1'b0;
    logic        lat_mode = 1'b0;
    logic [31:0] cur_res;
    logic [4:0]  cur_flg;
    logic        stall_seen = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_flg;
    logic [3:0]  held_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input vec_t v, input logic [3:0] tag);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        op_a       = v.a;
        op_b       = v.b;
        round_mode = v.rm;
        in_tag     = tag;
        cur_res    = v.res;
        cur_flg    = v.flg;
        in_valid   = 1'b1;
        while (!acc && guard < 200) begin
            #1;
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic drain(input int budget);
        int g;
        g = 0;
        while (sb.size() != 0 && g < budget) begin
            tick();
            g++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: handshakes are decided by values stable at the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stall_seen = 1'b0;
        end else begin
            sb_t e;
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(sb.size() == 3 && !out_ready)});
            if (stall_seen) begin
                chk("held_valid", {63'd0, out_valid}, 64'd1);
                chk("held_result", {27'd0, flags, result}, {27'd0, held_flg, held_res});
                chk("held_tag", {60'd0, out_tag}, {60'd0, held_tag});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h tag %0d, expected none",
                             result, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("result", {32'd0, result}, {32'd0, e.res});
                    chk("flags", {59'd0, flags}, {59'd0, e.flg});
                    chk("tag", {60'd0, out_tag}, {60'd0, e.tag});
                    if (lat_mode) chk("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            stall_seen = out_valid && !out_ready;
            held_res   = result;
            held_flg   = flags;
            held_tag   = out_tag;
            if (in_valid && in_ready) begin
                e.res = cur_res;
                e.flg = cur_flg;
                e.tag = in_tag;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    initial begin
        vt[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};
        vt[1]  = '{32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 5'b00001};
        vt[2]  = '{32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 5'b00001};
        vt[3]  = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 5'b00101};
        vt[4]  = '{32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 5'b00101};
        vt[5]  = '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 5'b00011};
        vt[6]  = '{32'h80800000, 32'h3F000000, 1'b0, 32'h80000000, 5'b00011};
        vt[7]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 5'b10000};
        vt[8]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000};
        vt[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000};
        vt[10] = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 5'b00000};
        vt[11] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40100000, 5'b00000};
        vt[12] = '{32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 5'b00001};
        vt[13] = '{32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 5'b00001};
        vt[14] = '{32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 5'b00000};
        vt[15] = '{32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 5'b00000};
        vt[16] = '{32'hC0000000, 32'h40400000, 1'b0, 32'hC0C00000, 5'b00000};
        vt[17] = '{32'h3F800000, 32'hFF800000, 1'b1, 32'hFF800000, 5'b00000};
        vt[18] = '{32'h7F800000, 32'h7FA00000, 1'b0, 32'h7FC00000, 5'b10000};
        vt[19] = '{32'h00000000, 32'h7F800000, 1'b0, 32'h7FC00000, 5'b10000};
        vt[20] = '{32'h3F000000, 32'h3F000000, 1'b0, 32'h3E800000, 5'b00000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op_a = '0;
        op_b = '0;
        round_mode = 1'b0;
        in_tag = '0;
        repeat (3) tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {27'd0, flags, result}, 64'd0);
        chk("rst_tag", {60'd0, out_tag}, 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back vectors with out_ready held high: fixed 3-cycle latency
        lat_mode = 1'b1;
        for (int i = 0; i < NV; i++) send(vt[i], 4'(i));
        drain(50);
        chk("table_count", 64'(n_out), 64'(NV));

        // Backpressure: 8 ops with tags 0..7, random out_ready
        lat_mode = 1'b0;
        bp_mode = 1'b1;
        n_out = 0;
        for (int i = 0; i < 8; i++) send(vt[i], 4'(i));
        drain(500);
        bp_mode = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(n_out), 64'd8);

        // Reset with three ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(vt[11 + i], 4'(i + 4));
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        n_out = 0;
        repeat (10) tick();
        chk("no_stale_output", 64'(n_out), 64'd0);
        lat_mode = 1'b1;
        send(vt[0], 4'd9);
        drain(20);
        chk("post_rst_count", 64'(n_out), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
